// File: rtl/dbg_cmd_pkg.sv
// Shared constants and types for the debug command path: default widths,
// virtual-JTAG instruction codes and the command entry layout.
package dbg_cmd_pkg;

  localparam int DEF_IR_W    = 2;
  localparam int DEF_SR_W    = 38;
  localparam int DEF_ACT_BIT = 35;

  localparam logic [DEF_IR_W-1:0] OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] TRACE     = 2'd1;
  localparam logic [DEF_IR_W-1:0] BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/dbg_strobe_sync.sv
// Brings one tck-domain strobe into clk through a flop chain and turns its
// rising edge into a single-cycle event.
module dbg_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], strobe};
      edge_q <= sync_p[SYNC_STAGES-1];
    end
  end

  assign ev = sync_p[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/dbg_cmd_sync_queue.sv
// System-clock side of the debug slave: captures Update-IR/Update-DR scans into
// a show-ahead command queue and decodes pops into action strobes.
// Optional saturating drop counter `ovf_cnt`: define DBG_CMD_SYNC_OVF_CNT_EN.
module dbg_cmd_sync_queue
  import dbg_cmd_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int SR_W        = DEF_SR_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [SR_W-1:0]      cmd_data,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 ir_update,
  output logic                 ovf,
  input  logic                 ovf_clr
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
  ,
  output logic [7:0]           ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NS = 2**IR_W;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  logic          uir_ev, udr_ev;
  logic [IR_W-1:0] ir_q;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, head_idx;
  logic [CW-1:0] count;
  logic          empty, full, pop, wr_en, drop;

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .strobe(vs_uir), .ev(uir_ev)
  );

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .strobe(vs_udr), .ev(udr_ev)
  );

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = ~empty & cmd_ready;
  assign wr_en = udr_ev & (~full | pop);
  assign drop  = udr_ev & full & ~pop;

  // When empty, the slot behind rd_ptr still holds the last popped command
  // and cannot be overwritten until the queue fills completely.
  assign head_idx  = empty ? (rd_ptr - AW'(1)) : rd_ptr;
  assign cmd_valid = ~empty;
  assign cmd_ir    = mem[head_idx].ir;
  assign cmd_data  = mem[head_idx].data;
  assign ir_update = uir_ev;

  // Push samples the IR held before this cycle's Update-IR takes effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (uir_ev) begin
      ir_q <= ir_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= '{ir: ir_q, data: sr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef DBG_CMD_SYNC_OVF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end
  end
`endif

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int i = 0; i < NS; i++) begin
      if (pop && (cmd_ir == IR_W'(i))) begin
        take_action[i]    = cmd_data[ACT_BIT];
        take_no_action[i] = ~cmd_data[ACT_BIT];
      end
    end
  end

endmodule

// File: tb/tb_dbg_cmd_sync_queue.sv
// Bench for dbg_cmd_sync_queue: directed vector table, hand-written corner
// sequences and a randomized run against a queue-level reference model.
`timescale 1ns/1ps
module tb_dbg_cmd_sync_queue;
  import dbg_cmd_pkg::*;

  localparam int IR_W        = DEF_IR_W;
  localparam int SR_W        = DEF_SR_W;
  localparam int ACT_BIT     = DEF_ACT_BIT;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NS          = 1 << IR_W;

  logic            clk = 1'b0;
  logic            reset, vs_uir, vs_udr, cmd_ready, ovf_clr;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            cmd_valid, ir_update, ovf;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [NS-1:0]   take_action, take_no_action;
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
  logic [7:0]      ovf_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dbg_cmd_sync_queue #(
    .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(ACT_BIT), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .take_action(take_action), .take_no_action(take_no_action), .ir_update(ir_update),
    .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic udr_pulse(input logic [SR_W-1:0] v);
    sr = v; vs_udr = 1'b1; nxt(); nxt(); vs_udr = 1'b0; nxt(); nxt(); nxt();
  endtask

  task automatic uir_pulse(input logic [IR_W-1:0] v);
    ir_in = v; vs_uir = 1'b1; nxt(); nxt(); vs_uir = 1'b0; nxt(); nxt(); nxt();
  endtask

  function automatic logic [SR_W-1:0] mk(input int i, input logic act);
    logic [SR_W-1:0] v;
    v = SR_W'(i) * 38'h1_0101 + 38'h0_4242_0000;
    v[ACT_BIT] = act;
    return v;
  endfunction

  task automatic drain_chk(input string name, input logic [IR_W-1:0] e_ir, input logic [SR_W-1:0] e_data);
    logic [NS-1:0] one;
    one = NS'(1) << e_ir;
    cmd_ready = 1'b1;
    #1;
    chk({name, "_valid"}, cmd_valid, 1'b1);
    chk({name, "_ir"}, cmd_ir, e_ir);
    chk({name, "_data"}, cmd_data, e_data);
    chk({name, "_ta"}, take_action, e_data[ACT_BIT] ? one : '0);
    chk({name, "_tna"}, take_no_action, e_data[ACT_BIT] ? '0 : one);
    nxt();
    cmd_ready = 1'b0;
  endtask

  // Reference model: command queue, last popped entry, latched IR, flags,
  // and strobe sample history giving event timing.
  dbg_cmd_t        mq[$];
  dbg_cmd_t        m_last;
  logic [IR_W-1:0] m_irq;
  logic            m_ovf;
  int              m_cnt;
  logic            hu[$], hd[$];

  task automatic model_reset();
    mq.delete(); hu.delete(); hd.delete();
    m_last = '0; m_irq = '0; m_ovf = 1'b0; m_cnt = 0;
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      hu.push_back(1'b0);
      hd.push_back(1'b0);
    end
  endtask

  task automatic model_cycle();
    logic eu, ed, pop, drop;
    dbg_cmd_t head;
    logic [NS-1:0] eta, etna;
    #1;
    eu = hu[hu.size()-SYNC_STAGES] && !hu[hu.size()-SYNC_STAGES-1];
    ed = hd[hd.size()-SYNC_STAGES] && !hd[hd.size()-SYNC_STAGES-1];
    head = (mq.size() > 0) ? mq[0] : m_last;
    pop = (mq.size() > 0) && cmd_ready;
    eta = '0; etna = '0;
    if (pop) begin
      if (head.data[ACT_BIT]) eta[head.ir] = 1'b1;
      else etna[head.ir] = 1'b1;
    end
    chk("rnd_valid", cmd_valid, mq.size() > 0);
    chk("rnd_ir", cmd_ir, head.ir);
    chk("rnd_data", cmd_data, head.data);
    chk("rnd_ta", take_action, eta);
    chk("rnd_tna", take_no_action, etna);
    chk("rnd_ir_update", ir_update, eu);
    chk("rnd_ovf", ovf, m_ovf);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("rnd_ovf_cnt", ovf_cnt, m_cnt);
`endif
    drop = ed && (mq.size() == DEPTH) && !pop;
    if (pop) m_last = mq.pop_front();
    if (ed && !drop) mq.push_back('{ir: m_irq, data: sr});
    if (eu) m_irq = ir_in;
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (drop) begin
      if (m_cnt < 255) m_cnt++;
    end else if (ovf_clr) m_cnt = 0;
    hu.push_back(vs_uir); void'(hu.pop_front());
    hd.push_back(vs_udr); void'(hd.pop_front());
    nxt();
  endtask

  typedef struct {
    logic            uir, udr;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
    logic            rdy;
    logic            e_vld;
    logic [IR_W-1:0] e_ir;
    logic [SR_W-1:0] e_data;
    logic [NS-1:0]   e_ta, e_tna;
    logic            e_iru;
  } vec_t;

  vec_t tbl[10];
  logic [SR_W-1:0] d[5];
  int kind, len, pct;

  initial begin
    logic [SR_W-1:0] sa;
    sa = 38'h08_1234_5678;
    tbl[0] = '{1'b1, 1'b0, BREAK, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, BREAK, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, BREAK, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, BREAK, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, BREAK, sa, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, BREAK, sa, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, BREAK, sa, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, BREAK, sa, 1'b0, 1'b1, BREAK, sa, '0, '0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, BREAK, sa, 1'b1, 1'b1, BREAK, sa, 4'b0100, '0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, BREAK, sa, 1'b0, 1'b0, BREAK, sa, '0, '0, 1'b0};

    reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    nxt(); nxt();
    cmd_ready = 1'b1;
    #1;
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_ir", cmd_ir, '0);
    chk("rst_data", cmd_data, '0);
    chk("rst_ta", take_action, '0);
    chk("rst_tna", take_no_action, '0);
    chk("rst_ir_update", ir_update, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("rst_ovf_cnt", ovf_cnt, 8'd0);
`endif
    reset = 1'b0; cmd_ready = 1'b0;
    nxt();

    // Basic capture, latency and decode
    for (int r = 0; r < 10; r++) begin
      vs_uir = tbl[r].uir; vs_udr = tbl[r].udr; ir_in = tbl[r].ir; sr = tbl[r].sr;
      cmd_ready = tbl[r].rdy;
      #1;
      chk($sformatf("t1_r%0d_valid", r), cmd_valid, tbl[r].e_vld);
      chk($sformatf("t1_r%0d_ir", r), cmd_ir, tbl[r].e_ir);
      chk($sformatf("t1_r%0d_data", r), cmd_data, tbl[r].e_data);
      chk($sformatf("t1_r%0d_ta", r), take_action, tbl[r].e_ta);
      chk($sformatf("t1_r%0d_tna", r), take_no_action, tbl[r].e_tna);
      chk($sformatf("t1_r%0d_ir_update", r), ir_update, tbl[r].e_iru);
      nxt();
    end
    cmd_ready = 1'b0;

    // Back-pressure and overflow
    for (int i = 0; i < 5; i++) d[i] = mk(i, (i % 2) == 1);
    for (int i = 0; i < 4; i++) udr_pulse(d[i]);
    chk("t2_ovf_before", ovf, 1'b0);
    udr_pulse(d[4]);
    chk("t2_ovf_after", ovf, 1'b1);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("t2_ovf_cnt", ovf_cnt, 8'd1);
`endif
    for (int i = 0; i < 4; i++) drain_chk($sformatf("t2_drain%0d", i), BREAK, d[i]);
    #1;
    chk("t2_empty", cmd_valid, 1'b0);
    ovf_clr = 1'b1; nxt(); ovf_clr = 1'b0;
    #1;
    chk("t2_ovf_clr", ovf, 1'b0);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("t2_ovf_cnt_clr", ovf_cnt, 8'd0);
`endif

    // Full queue, push and pop in the same cycle
    for (int i = 0; i < 5; i++) d[i] = mk(10 + i, (i % 2) == 0);
    for (int i = 0; i < 4; i++) udr_pulse(d[i]);
    sr = d[4]; vs_udr = 1'b1; nxt(); nxt(); vs_udr = 1'b0;
    cmd_ready = 1'b1;
    #1;
    chk("t3_pop_data", cmd_data, d[0]);
    chk("t3_pop_ta", take_action, 4'b0100);
    nxt(); cmd_ready = 1'b0; nxt(); nxt();
    chk("t3_ovf", ovf, 1'b0);
    for (int i = 1; i < 5; i++) drain_chk($sformatf("t3_drain%0d", i), BREAK, d[i]);
    #1;
    chk("t3_empty", cmd_valid, 1'b0);

    // Simultaneous Update-IR and Update-DR
    uir_pulse(TRACECTRL);
    d[0] = mk(20, 1'b1); d[1] = mk(21, 1'b0);
    ir_in = TRACE; sr = d[0]; vs_uir = 1'b1; vs_udr = 1'b1;
    nxt(); nxt(); vs_uir = 1'b0; vs_udr = 1'b0; nxt(); nxt(); nxt();
    udr_pulse(d[1]);
    drain_chk("t4_first", TRACECTRL, d[0]);
    drain_chk("t4_second", TRACE, d[1]);

    // Reset with commands queued
    for (int i = 0; i < 3; i++) udr_pulse(mk(30 + i, 1'b1));
    chk("t5_valid_before", cmd_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_valid_async", cmd_valid, 1'b0);
    chk("t5_data_async", cmd_data, '0);
    nxt(); nxt(); reset = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_idle%0d_valid", i), cmd_valid, 1'b0);
      chk($sformatf("t5_idle%0d_strobes", i), {take_action, take_no_action}, '0);
      nxt();
    end
    cmd_ready = 1'b0;
    d[0] = mk(50, 1'b1);
    udr_pulse(d[0]);
    drain_chk("t5_new", OCIMEM, d[0]);

    // ovf_clr against a same-cycle drop
    for (int i = 0; i < 4; i++) udr_pulse(mk(60 + i, 1'b0));
    chk("t6_ovf_full", ovf, 1'b0);
    sr = mk(64, 1'b0); vs_udr = 1'b1; nxt(); nxt(); vs_udr = 1'b0;
    ovf_clr = 1'b1; nxt(); ovf_clr = 1'b0;
    chk("t6_ovf_set_wins", ovf, 1'b1);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("t6_ovf_cnt", ovf_cnt, 8'd1);
`endif
    ovf_clr = 1'b1; nxt(); ovf_clr = 1'b0;
    chk("t6_ovf_cleared", ovf, 1'b0);
`ifdef DBG_CMD_SYNC_OVF_CNT_EN
    chk("t6_ovf_cnt_cleared", ovf_cnt, 8'd0);
`endif

    // Randomized run against the reference model
    reset = 1'b1; nxt(); nxt(); reset = 1'b0;
    model_reset();
    for (int t = 0; t < 160; t++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(5, 8);
      pct  = ((t / 40) % 2 == 1) ? 60 : 4;
      ir_in = IR_W'($urandom);
      sr    = SR_W'({$urandom, $urandom});
      for (int c = 0; c < len; c++) begin
        vs_udr    = (c < 2) && kind[0];
        vs_uir    = (c < 2) && kind[1];
        cmd_ready = ($urandom_range(0, 99) < pct);
        ovf_clr   = ($urandom_range(0, 15) == 0);
        model_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
